// File: rtl/lcd_tile_writer_pkg.sv
// Shared constants and types for the LCD command-stream generator:
// UC1701 init bytes, opcode/mode constants and the sequencer state set.
package lcd_pkg;

  localparam int INIT_LEN = 14;

  // Power-up sequence for the DOGS102 panel, played once after reset.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'h40, 8'hA1, 8'hC0, 8'hA6, 8'hA2, 8'h2F, 8'hF8,
    8'h00, 8'h27, 8'h81, 8'h10, 8'hFA, 8'h90, 8'hAF
  };

  // Controller opcodes; the low bits carry the page or column nibble.
  localparam logic [7:0] SET_PAGE = 8'hB0;
  localparam logic [7:0] COL_LO   = 8'h00;
  localparam logic [7:0] COL_HI   = 8'h10;

  // Bit 8 of each FIFO word selects command or display data.
  localparam logic MODE_CMD  = 1'b0;
  localparam logic MODE_DATA = 1'b1;

  typedef enum logic [3:0] {
    INIT,
    CLR_PAGE,
    CLR_COLLO,
    CLR_COLHI,
    CLR_DATA,
    IDLE,
    T_PAGE,
    T_COLLO,
    T_COLHI,
    T_DATA
  } state_t;

endpackage

// File: rtl/lcd_tile_writer_if.sv
// Request handshake plus FIFO write port of the LCD tile writer.
// master = request source / FIFO side, slave = the tile writer itself.
interface lcd_tile_writer_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [4:0] req_x;
  logic [2:0] req_y;
  logic [7:0] req_pattern;
  logic [8:0] cmd;
  logic       wr;
  logic       full;
  logic       busy;

  modport master (
    output req_valid, req_op, req_x, req_y, req_pattern, full,
    input  req_ready, cmd, wr, busy
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_pattern, full,
    output req_ready, cmd, wr, busy
  );

endinterface

// File: rtl/lcd_tile_writer.sv
// LCD command-stream generator. Plays the panel init sequence and a full
// clear after reset, then expands tile-draw and clear requests into 9-bit
// {mode, byte} FIFO words, throttled by the FIFO full flag.
module lcd_tile_writer
  import lcd_pkg::*;
#(
  parameter int TILE_W     = 4,
  parameter int LCD_COLS   = 102,
  parameter int COL_OFFSET = 0
) (
  input  logic               Bus2IP_Clk,
  input  logic               rst,
  lcd_tile_writer_if.slave   bus
);

  localparam logic [7:0] COL_BASE      = 8'(COL_OFFSET);
  localparam logic [7:0] LAST_COL      = 8'(LCD_COLS - 1);
  localparam logic [7:0] LAST_TILE_COL = 8'(TILE_W - 1);
  localparam logic [3:0] LAST_INIT     = 4'(INIT_LEN - 1);
  localparam logic [2:0] LAST_PAGE     = 3'd7;

  state_t     state;
  logic [3:0] init_idx;
  logic [2:0] page;
  logic [7:0] col_cnt;
  logic [2:0] tile_page;
  logic [7:0] tile_col;
  logic [7:0] tile_pattern;

  logic [7:0] init_byte;
  logic [7:0] req_col;
  logic       req_oob;
  logic       emitting;
  logic       advance;
  logic [8:0] cmd_word;

  // Column address and visibility of an incoming tile request.
  assign req_col = 8'(32'(bus.req_x) * TILE_W + COL_OFFSET);
  assign req_oob = (32'(bus.req_x) * TILE_W + TILE_W) > LCD_COLS;

  // A word leaves only when a word is on offer and the FIFO has room.
  assign emitting = (state != IDLE);
  assign advance  = emitting && !bus.full;

  assign bus.wr        = advance;
  assign bus.cmd       = cmd_word;
  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);

  // Init ROM lookup by step index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through the case can infer a latch.
    init_byte = 8'h00;
    case (init_idx)
      4'd0:  init_byte = INIT_ROM[0];
      4'd1:  init_byte = INIT_ROM[1];
      4'd2:  init_byte = INIT_ROM[2];
      4'd3:  init_byte = INIT_ROM[3];
      4'd4:  init_byte = INIT_ROM[4];
      4'd5:  init_byte = INIT_ROM[5];
      4'd6:  init_byte = INIT_ROM[6];
      4'd7:  init_byte = INIT_ROM[7];
      4'd8:  init_byte = INIT_ROM[8];
      4'd9:  init_byte = INIT_ROM[9];
      4'd10: init_byte = INIT_ROM[10];
      4'd11: init_byte = INIT_ROM[11];
      4'd12: init_byte = INIT_ROM[12];
      4'd13: init_byte = INIT_ROM[13];
      default: init_byte = 8'h00;
    endcase
  end

  // Word presented to the FIFO, decoded from state and step counters only.
  always_comb begin
    cmd_word = {MODE_CMD, 8'h00};
    case (state)
      INIT:      cmd_word = {MODE_CMD, init_byte};
      CLR_PAGE:  cmd_word = {MODE_CMD, SET_PAGE | {5'b0, page}};
      CLR_COLLO: cmd_word = {MODE_CMD, COL_LO | {4'b0, COL_BASE[3:0]}};
      CLR_COLHI: cmd_word = {MODE_CMD, COL_HI | {4'b0, COL_BASE[7:4]}};
      CLR_DATA:  cmd_word = {MODE_DATA, 8'h00};
      T_PAGE:    cmd_word = {MODE_CMD, SET_PAGE | {5'b0, tile_page}};
      T_COLLO:   cmd_word = {MODE_CMD, COL_LO | {4'b0, tile_col[3:0]}};
      T_COLHI:   cmd_word = {MODE_CMD, COL_HI | {4'b0, tile_col[7:4]}};
      T_DATA:    cmd_word = {MODE_DATA, tile_pattern};
      default:   cmd_word = {MODE_CMD, 8'h00};
    endcase
  end

  // Sequencer: steps only on accepted words, captures requests in IDLE.
  always_ff @(posedge Bus2IP_Clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (rst) begin
      state        <= INIT;
      init_idx     <= 4'd0;
      page         <= 3'd0;
      col_cnt      <= 8'd0;
      tile_page    <= 3'd0;
      tile_col     <= 8'd0;
      tile_pattern <= 8'd0;
    end else begin
      case (state)
        INIT: begin
          if (advance) begin
            if (init_idx == LAST_INIT) begin
              init_idx <= 4'd0;
              page     <= 3'd0;
              state    <= CLR_PAGE;
            end else begin
              init_idx <= init_idx + 4'd1;
            end
          end
        end

        CLR_PAGE: if (advance) state <= CLR_COLLO;

        CLR_COLLO: if (advance) state <= CLR_COLHI;

        CLR_COLHI: begin
          if (advance) begin
            col_cnt <= 8'd0;
            state   <= CLR_DATA;
          end
        end

        CLR_DATA: begin
          if (advance) begin
            if (col_cnt == LAST_COL) begin
              col_cnt <= 8'd0;
              if (page == LAST_PAGE) begin
                page  <= 3'd0;
                state <= IDLE;
              end else begin
                page  <= page + 3'd1;
                state <= CLR_PAGE;
              end
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end

        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_op) begin
              page  <= 3'd0;
              state <= CLR_PAGE;
            end else if (!req_oob) begin
              tile_page    <= bus.req_y;
              tile_col     <= req_col;
              tile_pattern <= bus.req_pattern;
              state        <= T_PAGE;
            end
            // An off-screen tile is consumed silently and the block stays idle.
          end
        end

        T_PAGE: if (advance) state <= T_COLLO;

        T_COLLO: if (advance) state <= T_COLHI;

        T_COLHI: begin
          if (advance) begin
            col_cnt <= 8'd0;
            state   <= T_DATA;
          end
        end

        T_DATA: begin
          if (advance) begin
            if (col_cnt == LAST_TILE_COL) begin
              col_cnt <= 8'd0;
              state   <= IDLE;
            end else begin
              col_cnt <= col_cnt + 8'd1;
            end
          end
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule
